// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - elastic pipeline-stage register with two-entry skid buffer
// Flush turns held entries into NOP bubbles; saturating bubble/stall counters for profiling.
module pipe_skid_reg #(
  parameter int unsigned           DATA_W    = 32,
  parameter logic [DATA_W-1:0]     NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned           CNT_W     = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              up_fire;
  logic              dn_fire;
  logic              bubble;
  logic              stall;

  // Handshake outputs decode the state register only, so no dn_ready -> up_ready path.
  assign up_ready  = (state != TWO);
  assign dn_valid  = (state != EMPTY);
  assign dn_data   = main_q;
  assign occupancy = 2'(state);

  assign up_fire = up_valid & up_ready;
  assign dn_fire = dn_valid & dn_ready;
  assign bubble  = dn_ready & ~dn_valid;
  assign stall   = dn_valid & ~dn_ready;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (up_fire) begin
            state  <= ONE;
            main_q <= up_data;
          end
        end
        ONE: begin
          if (up_fire && !dn_fire) begin
            state  <= TWO;
            skid_q <= up_data;
          end else if (up_fire) begin
            main_q <= up_data;
          end else if (dn_fire) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
          end
        end
        TWO: begin
          if (dn_fire) begin
            state  <= ONE;
            main_q <= skid_q;
            skid_q <= NOP_VALUE;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= NOP_VALUE;
          skid_q <= NOP_VALUE;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; flush leaves the counters alone.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (bubble && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall && stall_cnt != CNT_MAX)   stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - scoreboard bench for pipe_skid_reg
// Two instances share stimulus: a wide-counter one and a 3-bit-counter one with a non-zero NOP.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam logic [DW-1:0] NOP_A = 32'h0000_0000;
  localparam logic [DW-1:0] NOP_B = 32'hFFFF_FFFF;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          up_valid = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic          dn_ready = 1'b0;
  logic          cnt_clr = 1'b0;

  logic          a_ready, a_valid, b_ready, b_valid;
  logic [DW-1:0] a_data, b_data;
  logic [1:0]    a_occ, b_occ;
  logic [15:0]   a_bub, a_stl;
  logic [2:0]    b_bub, b_stl;

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP_A), .CNT_W(16)) u_a (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(a_ready), .up_data(up_data),
    .dn_valid(a_valid), .dn_ready(dn_ready), .dn_data(a_data),
    .occupancy(a_occ), .cnt_clr(cnt_clr), .bubble_cnt(a_bub), .stall_cnt(a_stl)
  );

  pipe_skid_reg #(.DATA_W(DW), .NOP_VALUE(NOP_B), .CNT_W(3)) u_b (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(b_ready), .up_data(up_data),
    .dn_valid(b_valid), .dn_ready(dn_ready), .dn_data(b_data),
    .occupancy(b_occ), .cnt_clr(cnt_clr), .bubble_cnt(b_bub), .stall_cnt(b_stl)
  );

  always #5 clk = ~clk;

  // Reference: FIFO of accepted payloads plus raw event counts since the last clear.
  logic [DW-1:0] exp_q[$];
  int  mdl_bub = 0;
  int  mdl_stl = 0;
  bit  mdl_ready = 1'b1;
  bit  mon_en = 1'b0;
  int  n_chk = 0;
  int  n_pass = 0;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares the presented output against the model, pops on a downstream transfer.
  int            sz;
  logic [DW-1:0] front;
  always @(negedge clk) begin
    if (mon_en) begin
      sz = exp_q.size();
      front = (sz > 0) ? exp_q[0] : '0;
      chk("a_valid", a_valid, sz > 0);
      chk("a_ready", a_ready, sz < 2);
      chk("a_occ", a_occ, sz);
      chk("a_data", a_data, (sz > 0) ? front : NOP_A);
      chk("b_valid", b_valid, sz > 0);
      chk("b_data", b_data, (sz > 0) ? front : NOP_B);
      chk("a_bubble", a_bub, sat(mdl_bub, MAX_A));
      chk("a_stall", a_stl, sat(mdl_stl, MAX_A));
      chk("b_bubble", b_bub, sat(mdl_bub, MAX_B));
      chk("b_stall", b_stl, sat(mdl_stl, MAX_B));
      mdl_ready = (sz < 2);
      if (sz > 0 && dn_ready) void'(exp_q.pop_front());
      if (cnt_clr) begin
        mdl_bub = 0;
        mdl_stl = 0;
      end else begin
        if (dn_ready && sz == 0) mdl_bub++;
        if (sz > 0 && !dn_ready) mdl_stl++;
      end
    end
  end

  // Stimulus: one cycle per call; accepted payloads are pushed to the scoreboard.
  task automatic step(input bit uv, input logic [DW-1:0] d, input bit dr, input bit fl, input bit clr);
    up_valid = uv;
    up_data  = d;
    dn_ready = dr;
    flush    = fl;
    cnt_clr  = clr;
    @(negedge clk);
    #1;
    if (fl) exp_q.delete();
    else if (uv && mdl_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, a_valid, 0);
    chk({tag, "_ready"}, a_ready, 1);
    chk({tag, "_data"}, a_data, NOP_A);
    chk({tag, "_bdata"}, b_data, NOP_B);
    chk({tag, "_occ"}, a_occ, 0);
    chk({tag, "_bub"}, a_bub, 0);
    chk({tag, "_stl"}, b_stl, 0);
  endtask

  task automatic restart_model();
    exp_q.delete();
    mdl_bub = 0;
    mdl_stl = 0;
    mdl_ready = 1'b1;
    mon_en = 1'b1;
  endtask

  logic [DW-1:0] stream_vals[4];

  initial begin
    stream_vals = '{32'h11, 32'h22, 32'h33, 32'h44};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    restart_model();

    repeat (10) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("idle_bubble", a_bub, 10);
    chk("idle_stall", a_stl, 0);
    chk("idle_bubble_sat3", b_bub, 7);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, stream_vals[i], 1'b1, 1'b0, 1'b0);
      chk("stream_occ", a_occ, 1);
      chk("stream_data", a_data, stream_vals[i]);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_stall", a_stl, 0);

    step(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0);
    chk("bp_occ", a_occ, 2);
    chk("bp_ready", a_ready, 0);
    chk("bp_data", a_data, 32'hA1);
    chk("bp_stall", a_stl, 3);
    step(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hA3, 1'b1, 1'b0, 1'b0);
    chk("bp_last", a_data, 32'hA3);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_stall_total", a_stl, 3);

    step(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hB3, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", a_valid, 0);
    chk("flush_data", a_data, NOP_A);
    chk("flush_occ", a_occ, 0);
    chk("flush_ready", a_ready, 1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("clr_bub3", b_bub, 0);
    chk("clr_bub", a_bub, 0);
    repeat (12) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sat_bub3", b_bub, 7);
    chk("sat_bub", a_bub, 12);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("clr_win_bub3", b_bub, 0);

    repeat (400)
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);

    step(1'b1, 32'hC1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    chk("pre_arst_occ", a_occ, 2);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    restart_model();
    step(1'b1, 32'hD1, 1'b1, 1'b0, 1'b0);
    chk("post_arst_data", a_data, 32'hD1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
